// File: rtl/gpu_isa_pkg.sv
// Shared ISA encodings and widths for the controller and the memory dispatch block.
// Pure declarations: no logic, no latency.
package gpu_isa_pkg;

    localparam int OP_W               = 4;
    localparam int IMM_W              = 16;
    localparam int REG_W              = 4;
    localparam int WORDS_PER_LINE_DEF = 4;

    typedef enum logic [OP_W-1:0] {
        OP_SMA    = 4'b0110,
        OP_LOADI  = 4'b0111,
        OP_LOADB  = 4'b1000,
        OP_WRITEB = 4'b1001
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RD1,
        S_RD2,
        S_WR,
        S_BUF_WAIT,
        S_SEND
    } md_state_t;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Block RAM, read-first, port A read/write, port B read-only.
// Read latency 1 cycle, or 2 with the output register (HIGH_PERFORMANCE); no backpressure.
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = "",
    localparam int   AW              = $clog2(RAM_DEPTH)
) (
    input  logic [AW-1:0]        addra,
    input  logic [AW-1:0]        addrb,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 clka,
    input  logic                 clkb,
    input  logic                 wea,
    input  logic                 ena,
    input  logic                 enb,
    input  logic                 rsta,
    input  logic                 rstb,
    input  logic                 regcea,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] douta,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_a;
    logic [RAM_WIDTH-1:0] ram_b;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                ram[addra] <= dina;
            end
            ram_a <= ram[addra];
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_b <= ram[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign douta = ram_a;
            assign doutb = ram_b;
        end else begin : g_out_reg
            always_ff @(posedge clka) begin
                if (rsta)        douta <= '0;
                else if (regcea) douta <= ram_a;
            end
            always_ff @(posedge clkb) begin
                if (rstb)        doutb <= '0;
                else if (regceb) doutb <= ram_b;
            end
        end
    endgenerate

endmodule

// File: rtl/mem_dispatch.sv
// Executes SMA/LOADI/LOADB/WRITEB against the data cache; LOADI and WRITEB read take 4 cycles.
// cmd_ready_out low while busy; LOADB waits on fma_buf_valid_in, WRITEB holds its line until fma_ready_in.
module mem_dispatch
    import gpu_isa_pkg::*;
#(
    parameter int    DATA_CACHE_WIDTH = 16,
    parameter int    WORDS_PER_LINE   = WORDS_PER_LINE_DEF,
    parameter int    DATA_CACHE_DEPTH = 4096,
    parameter string INIT_FILE        = "",
    localparam int   LW               = DATA_CACHE_WIDTH * WORDS_PER_LINE,
    localparam int   AW               = $clog2(DATA_CACHE_DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [OP_W-1:0]   cmd_op_in,
    input  logic [REG_W-1:0]  cmd_word_in,
    input  logic [IMM_W-1:0]  cmd_imm_in,
    output logic              fma_buf_req_out,
    input  logic              fma_buf_valid_in,
    input  logic [LW-1:0]     fma_buf_in,
    output logic              fma_valid_out,
    input  logic              fma_ready_in,
    output logic [LW-1:0]     fma_data_out,
    output logic [AW-1:0]     mem_addr_out,
    output logic              err_out
);

    md_state_t            state_q, state_d;
    logic [AW-1:0]        addr_q;
    logic [IMM_W-1:0]     imm_q;
    logic [REG_W-1:0]     word_q;
    logic                 writeb_q;
    logic [LW-1:0]        wr_line_q;
    logic [LW-1:0]        merged;
    logic [LW-1:0]        ram_dout;
    logic [LW-1:0]        ram_din;
    logic [LW-1:0]        doutb_unused;
    logic                 ram_we;
    logic                 accept;
    logic                 imm_ok;
    logic                 word_ok;
    logic                 cmd_err;

    assign accept  = cmd_valid_in && cmd_ready_out;
    // An address immediate is only usable if nothing is lost by truncating it to AW bits.
    assign imm_ok  = (32'(cmd_imm_in) >> AW) == 32'd0;
    assign word_ok = 32'(cmd_word_in) < WORDS_PER_LINE;

    always_comb begin
        state_d = state_q;
        cmd_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op_in)
                        OP_SMA:    cmd_err = !imm_ok;
                        OP_LOADI:  if (word_ok) state_d = S_ISSUE;    else cmd_err = 1'b1;
                        OP_LOADB:  if (imm_ok)  state_d = S_BUF_WAIT; else cmd_err = 1'b1;
                        OP_WRITEB: if (imm_ok)  state_d = S_ISSUE;    else cmd_err = 1'b1;
                        default:   cmd_err = 1'b1;
                    endcase
                end
            end
            S_ISSUE:    state_d = S_RD1;
            S_RD1:      state_d = S_RD2;
            S_RD2:      state_d = writeb_q ? S_SEND : S_WR;
            S_WR:       state_d = S_IDLE;
            S_BUF_WAIT: if (fma_buf_valid_in) state_d = S_IDLE;
            S_SEND:     if (fma_ready_in)     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        merged = ram_dout;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (32'(word_q) == w) begin
                merged[w*DATA_CACHE_WIDTH +: DATA_CACHE_WIDTH] = DATA_CACHE_WIDTH'(imm_q);
            end
        end
    end

    // Both cache writers share port A; the merged line is registered so the write is a clean edge.
    assign ram_we  = (state_q == S_WR) || ((state_q == S_BUF_WAIT) && fma_buf_valid_in);
    assign ram_din = (state_q == S_WR) ? wr_line_q : fma_buf_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= S_IDLE;
            cmd_ready_out   <= 1'b0;
            mem_addr_out    <= '0;
            addr_q          <= '0;
            imm_q           <= '0;
            word_q          <= '0;
            writeb_q        <= 1'b0;
            wr_line_q       <= '0;
            fma_buf_req_out <= 1'b0;
            fma_valid_out   <= 1'b0;
            fma_data_out    <= '0;
            err_out         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_ready_out   <= (state_d == S_IDLE);
            err_out         <= cmd_err;
            fma_buf_req_out <= (state_d == S_BUF_WAIT);
            fma_valid_out   <= (state_d == S_SEND);
            if (accept) begin
                imm_q    <= cmd_imm_in;
                word_q   <= cmd_word_in;
                writeb_q <= (cmd_op_in == OP_WRITEB);
                addr_q   <= (cmd_op_in == OP_LOADI) ? mem_addr_out : AW'(cmd_imm_in);
                if ((cmd_op_in == OP_SMA) && imm_ok) begin
                    mem_addr_out <= AW'(cmd_imm_in);
                end
            end
            if (state_q == S_RD2) begin
                if (writeb_q) fma_data_out <= ram_dout;
                else          wr_line_q    <= merged;
            end
        end
    end

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH       (LW),
        .RAM_DEPTH       (DATA_CACHE_DEPTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (INIT_FILE)
    ) u_data_cache (
        .addra  (addr_q),
        .addrb  ('0),
        .dina   (ram_din),
        .clka   (clk_in),
        .clkb   (clk_in),
        .wea    (ram_we),
        .ena    (1'b1),
        .enb    (1'b0),
        .rsta   (1'b0),
        .rstb   (1'b0),
        .regcea (1'b1),
        .regceb (1'b0),
        .douta  (ram_dout),
        .doutb  (doutb_unused)
    );

endmodule

// File: tb/tb_mem_dispatch.sv
// Directed plus randomized bench for mem_dispatch against a line-level cache model.
module tb_mem_dispatch;
    import gpu_isa_pkg::*;

    localparam int DW  = 16;
    localparam int LW  = 64;
    localparam int AW  = 12;

    logic          clk_in           = 1'b0;
    logic          rst_in           = 1'b1;
    logic          cmd_valid_in     = 1'b0;
    logic          cmd_ready_out;
    logic [3:0]    cmd_op_in        = '0;
    logic [3:0]    cmd_word_in      = '0;
    logic [15:0]   cmd_imm_in       = '0;
    logic          fma_buf_req_out;
    logic          fma_buf_valid_in = 1'b0;
    logic [LW-1:0] fma_buf_in       = '0;
    logic          fma_valid_out;
    logic          fma_ready_in     = 1'b0;
    logic [LW-1:0] fma_data_out;
    logic [AW-1:0] mem_addr_out;
    logic          err_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [LW-1:0] model [int];
    int model_addr = 0;

    mem_dispatch dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .cmd_valid_in     (cmd_valid_in),
        .cmd_ready_out    (cmd_ready_out),
        .cmd_op_in        (cmd_op_in),
        .cmd_word_in      (cmd_word_in),
        .cmd_imm_in       (cmd_imm_in),
        .fma_buf_req_out  (fma_buf_req_out),
        .fma_buf_valid_in (fma_buf_valid_in),
        .fma_buf_in       (fma_buf_in),
        .fma_valid_out    (fma_valid_out),
        .fma_ready_in     (fma_ready_in),
        .fma_data_out     (fma_data_out),
        .mem_addr_out     (mem_addr_out),
        .err_out          (err_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [3:0] w, input logic [15:0] imm);
        int n = 0;
        @(negedge clk_in);
        while (!cmd_ready_out && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        chk("cmd_ready_wait", 64'(n < 40), 64'd1);
        cmd_op_in    = op;
        cmd_word_in  = w;
        cmd_imm_in   = imm;
        cmd_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        cmd_valid_in = 1'b0;
    endtask

    task automatic loadb(input logic [15:0] a, input logic [LW-1:0] data, input int delay);
        int hi = 0;
        do_cmd(OP_LOADB, 4'd0, a);
        repeat (delay) begin
            @(negedge clk_in);
            if (fma_buf_req_out) hi++;
        end
        fma_buf_in       = data;
        fma_buf_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        fma_buf_valid_in = 1'b0;
        @(negedge clk_in);
        chk("loadb_req_cycles", 64'(hi), 64'(delay));
        chk("loadb_req_drop", 64'(fma_buf_req_out), 64'd0);
        model[int'(a)] = data;
    endtask

    task automatic loadi(input logic [3:0] w, input logic [15:0] v);
        logic [LW-1:0] line;
        int n = 0;
        do_cmd(OP_LOADI, w, v);
        @(negedge clk_in);
        while (!cmd_ready_out && n < 20) begin
            n++;
            @(negedge clk_in);
        end
        chk("loadi_busy_cycles", 64'(n), 64'd4);
        line = model[model_addr];
        line[int'(w)*DW +: DW] = v;
        model[model_addr] = line;
    endtask

    task automatic writeb(input logic [15:0] a, input int stall, input logic [LW-1:0] exp);
        int n = 0;
        int held = 0;
        bit stable = 1'b1;
        logic [LW-1:0] d0;
        do_cmd(OP_WRITEB, 4'd0, a);
        @(negedge clk_in);
        while (!fma_valid_out && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk("writeb_latency", 64'(n), 64'd3);
        d0 = fma_data_out;
        chk("writeb_data", d0, exp);
        repeat (stall) begin
            if (fma_valid_out) held++;
            if (fma_data_out !== d0) stable = 1'b0;
            @(negedge clk_in);
        end
        fma_ready_in = 1'b1;
        if (fma_valid_out) held++;
        if (fma_data_out !== d0) stable = 1'b0;
        @(negedge clk_in);
        fma_ready_in = 1'b0;
        chk("writeb_valid_cycles", 64'(held), 64'(stall + 1));
        chk("writeb_data_stable", 64'(stable), 64'd1);
        chk("writeb_valid_drop", 64'(fma_valid_out), 64'd0);
        chk("writeb_ready_after", 64'(cmd_ready_out), 64'd1);
    endtask

    task automatic err_cmd(input string tag, input logic [3:0] op, input logic [3:0] w,
                           input logic [15:0] imm);
        logic [AW-1:0] a0;
        a0 = mem_addr_out;
        do_cmd(op, w, imm);
        @(negedge clk_in);
        chk({tag, "_pulse"}, 64'(err_out), 64'd1);
        @(negedge clk_in);
        chk({tag, "_clear"}, 64'(err_out), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr_out), 64'(a0));
        chk({tag, "_idle"}, 64'(cmd_ready_out), 64'd1);
        chk({tag, "_noreq"}, 64'(fma_buf_req_out | fma_valid_out), 64'd0);
    endtask

    initial begin
        logic [LW-1:0] rnd;
        repeat (3) @(negedge clk_in);
        chk("rst_ready", 64'(cmd_ready_out), 64'd0);
        chk("rst_req", 64'(fma_buf_req_out), 64'd0);
        chk("rst_fma_valid", 64'(fma_valid_out), 64'd0);
        chk("rst_fma_data", fma_data_out, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_out), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_rst", 64'(cmd_ready_out), 64'd1);

        // Known contents first, then the word merge on top of them.
        rnd = {$urandom, $urandom};
        loadb(16'h0010, rnd, 1);
        do_cmd(OP_SMA, 4'd0, 16'h0010);
        model_addr = 16'h0010;
        @(negedge clk_in);
        chk("sma_addr", 64'(mem_addr_out), 64'h010);
        loadi(4'd2, 16'hBEEF);
        writeb(16'h0010, 0, model[16'h0010]);
        chk("loadi_word2", 64'(fma_data_out[2*DW +: DW]), 64'hBEEF);

        loadb(16'h0020, 64'h1111_2222_3333_4444, 5);
        writeb(16'h0020, 0, 64'h1111_2222_3333_4444);
        writeb(16'h0010, 3, model[16'h0010]);

        err_cmd("err_loadi_word", OP_LOADI, 4'd5, 16'h1234);
        err_cmd("err_sma_range", OP_SMA, 4'd0, 16'h1000);
        err_cmd("err_opcode", 4'b0011, 4'd0, 16'h0010);
        err_cmd("err_loadb_range", OP_LOADB, 4'd0, 16'h8000);
        err_cmd("err_writeb_range", OP_WRITEB, 4'd0, 16'hF000);
        writeb(16'h0010, 0, model[16'h0010]);
        writeb(16'h0020, 0, model[16'h0020]);

        @(negedge clk_in);
        cmd_op_in    = OP_SMA;
        cmd_imm_in   = 16'h0001;
        cmd_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("b2b_ready_second", 64'(cmd_ready_out), 64'd1);
        cmd_imm_in = 16'h0002;
        @(posedge clk_in);
        #1;
        cmd_valid_in = 1'b0;
        @(negedge clk_in);
        chk("b2b_addr", 64'(mem_addr_out), 64'h002);

        // Abort a LOADI while its read data is on the BRAM output.
        do_cmd(OP_SMA, 4'd0, 16'h0020);
        do_cmd(OP_LOADI, 4'd1, 16'($urandom));
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(cmd_ready_out), 64'd0);
        chk("rst_mid_fma_data", fma_data_out, 64'd0);
        chk("rst_mid_mem_addr", 64'(mem_addr_out), 64'd0);
        chk("rst_mid_flags", 64'({fma_buf_req_out, fma_valid_out, err_out}), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_addr = 0;
        writeb(16'h0020, 0, model[16'h0020]);

        for (int i = 0; i < 8; i++) begin
            loadb(16'(16'h0100 + i), {$urandom, $urandom}, int'($urandom_range(1, 4)));
        end
        for (int i = 0; i < 40; i++) begin
            int sel;
            int a;
            sel = int'($urandom_range(0, 3));
            a   = 16'h0100 + int'($urandom_range(0, 7));
            if (sel == 1 && !model.exists(model_addr)) sel = 0;
            case (sel)
                0: begin
                    do_cmd(OP_SMA, 4'd0, 16'(a));
                    model_addr = a;
                    @(negedge clk_in);
                    chk("rand_sma_addr", 64'(mem_addr_out), 64'(a));
                end
                1: loadi(4'($urandom_range(0, 3)), 16'($urandom));
                2: loadb(16'(a), {$urandom, $urandom}, int'($urandom_range(1, 4)));
                default: writeb(16'(a), int'($urandom_range(0, 3)), model[a]);
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            writeb(16'(16'h0100 + i), 0, model[16'h0100 + i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
